// File: rtl/my_control_if.sv
// Handshake and datapath-control bundle between the sequencer and its requester/datapath.
// The requester drives run/ir/g_zero; the sequencer drives enables, ALU select, addr, done, busy.
interface my_control_if #(
  parameter int ADDR_W = 9
);
  logic              run;
  logic [15:0]       ir;
  logic              g_zero;
  logic [2:0]        addsub;
  logic [9:0]        reg_enable_out;
  logic [10:0]       reg_enable_in;
  logic [ADDR_W-1:0] addr;
  logic              done;
  logic              busy;

  modport master (
    output run, ir, g_zero,
    input  addsub, reg_enable_out, reg_enable_in, addr, done, busy
  );

  modport slave (
    input  run, ir, g_zero,
    output addsub, reg_enable_out, reg_enable_in, addr, done, busy
  );
endinterface

// File: rtl/my_control.sv
// Instruction sequencer T0..T3; 1 step for mv/mvi/jmp/111, 3 steps for ALU ops; MVNZ_EN makes 111 = mvnz.
// No backpressure: run is sampled only in T0, any run seen while busy is dropped, not queued.
module my_control #(
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  my_control_if.slave bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_X111 = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  opcode, rx, ry;
  logic [2:0]  addsub;
  logic [9:0]  en_out;
  logic [10:0] en_in;
  logic        done;

  assign opcode = ir_q[15:13];
  assign rx     = ir_q[12:10];
  assign ry     = ir_q[9:7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    addsub  = 3'b000;
    en_out  = '0;
    en_in   = '0;
    done    = 1'b0;
    unique case (state_q)
      T0: begin
        if (bus.run) begin
          ir_d    = bus.ir;
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        done    = 1'b1;
        unique case (opcode)
          OP_MV: begin
            en_out = 10'd1 << ry;
            en_in  = 11'd1 << rx;
          end
          OP_MVI: begin
            en_out = 10'h200;
            en_in  = 11'd1 << rx;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            en_out  = 10'd1 << rx;
            en_in   = 11'h200;
            done    = 1'b0;
            state_d = T2;
          end
          OP_JMP: begin
            en_in = 11'h400;
          end
          OP_X111: begin
`ifdef MVNZ_EN
            if (!bus.g_zero) begin
              en_out = 10'd1 << ry;
              en_in  = 11'd1 << rx;
            end
`endif
          end
          default: ;
        endcase
      end
      T2: begin
        en_out  = 10'd1 << ry;
        en_in   = 11'h100;
        // ALU opcodes 010..101 map onto ALU codes 000..011
        addsub  = opcode - 3'd2;
        state_d = T3;
      end
      T3: begin
        en_out  = 10'h100;
        en_in   = 11'd1 << rx;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

`ifndef MVNZ_EN
  logic unused_g_zero;
  assign unused_g_zero = bus.g_zero;
`endif

  assign bus.addsub         = addsub;
  assign bus.reg_enable_out = en_out;
  assign bus.reg_enable_in  = en_in;
  assign bus.addr           = ir_q[ADDR_W-1:0];
  assign bus.done           = done;
  assign bus.busy           = (state_q != T0);

endmodule

// File: tb/tb_my_control.sv
// Randomised bench for my_control against a per-instruction expected-step queue model.
// Inputs are driven and outputs checked on the falling edge of clk.
module tb_my_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  my_control_if #(.ADDR_W(9)) bus ();

  my_control #(.ADDR_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [9:0]  eout;
    logic [10:0] ein;
    logic [2:0]  alu;
    logic        done;
  } step_t;

  step_t       q[$];
  logic [15:0] model_ir = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle behaviour of one instruction, straight from the opcode table.
  task automatic push_instr(input logic [15:0] i, input logic gz);
    int op, rx, ry;
    logic [9:0]  o_rx, o_ry;
    logic [10:0] i_rx;
    op = int'(i[15:13]);
    rx = int'(i[12:10]);
    ry = int'(i[9:7]);
    o_rx = 10'd1 << rx;
    o_ry = 10'd1 << ry;
    i_rx = 11'd1 << rx;
    case (op)
      0: q.push_back('{o_ry, i_rx, 3'd0, 1'b1});
      1: q.push_back('{10'h200, i_rx, 3'd0, 1'b1});
      2, 3, 4, 5: begin
        q.push_back('{o_rx, 11'h200, 3'd0, 1'b0});
        q.push_back('{o_ry, 11'h100, 3'(op - 2), 1'b0});
        q.push_back('{10'h100, i_rx, 3'd0, 1'b1});
      end
      6: q.push_back('{10'h000, 11'h400, 3'd0, 1'b1});
      default: begin
`ifdef MVNZ_EN
        if (!gz) q.push_back('{o_ry, i_rx, 3'd0, 1'b1});
        else     q.push_back('{10'h000, 11'h000, 3'd0, 1'b1});
`else
        q.push_back('{10'h000, 11'h000, 3'd0, 1'b1});
`endif
      end
    endcase
  endtask

  task automatic compare_all();
    step_t e;
    e = (q.size() != 0) ? q[0] : '0;
    check_eq("reg_enable_out", 32'(bus.reg_enable_out), 32'(e.eout));
    check_eq("reg_enable_in",  32'(bus.reg_enable_in),  32'(e.ein));
    check_eq("addsub",         32'(bus.addsub),         32'(e.alu));
    check_eq("done",           32'(bus.done),           32'(e.done));
    check_eq("busy",           32'(bus.busy),           32'(q.size() != 0));
    check_eq("addr",           32'(bus.addr),           32'(model_ir[8:0]));
    check_eq("out_onehot0",    32'($countones(bus.reg_enable_out) <= 1), 32'd1);
  endtask

  // One clock: drive at the falling edge, let the rising edge happen, check at the next falling edge.
  task automatic step(input logic r, input logic [15:0] i, input logic gz);
    logic idle_now;
    idle_now = (q.size() == 0);
    if (!idle_now) void'(q.pop_front());
    bus.run    = r;
    bus.ir     = i;
    bus.g_zero = gz;
    if (idle_now && r) begin
      model_ir = i;
      push_instr(i, gz);
    end
    @(negedge clk);
    compare_all();
    if (bus.done) done_cnt++;
  endtask

  task automatic mid_cycle_reset();
    #2 rst = 1'b0;
    #1;
    q.delete();
    model_ir = '0;
    compare_all();
    @(negedge clk);
    compare_all();
    rst = 1'b1;
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.ir     = '0;
    bus.g_zero = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // mv r3,r5
    step(1'b1, 16'h0E80, 1'b0);
    check_eq("mv_out", 32'(bus.reg_enable_out), 32'h020);
    check_eq("mv_in",  32'(bus.reg_enable_in),  32'h008);
    check_eq("mv_done", 32'(bus.done), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("mv_busy_after", 32'(bus.busy), 32'd0);

    // add r1,r2
    step(1'b1, 16'h4500, 1'b0);
    check_eq("add_t1_out", 32'(bus.reg_enable_out), 32'h002);
    check_eq("add_t1_in",  32'(bus.reg_enable_in),  32'h200);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("add_t2_out", 32'(bus.reg_enable_out), 32'h004);
    check_eq("add_t2_in",  32'(bus.reg_enable_in),  32'h100);
    check_eq("add_t2_alu", 32'(bus.addsub), 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("add_t3_out", 32'(bus.reg_enable_out), 32'h100);
    check_eq("add_t3_in",  32'(bus.reg_enable_in),  32'h002);
    check_eq("add_t3_done", 32'(bus.done), 32'd1);
    step(1'b0, 16'h0000, 1'b0);

    // sub r4,r4 with run held high: one done every 4 cycles
    done_cnt = 0;
    for (int k = 0; k < 12; k++) step(1'b1, 16'h7200, 1'b0);
    check_eq("sub_held_dones", 32'(done_cnt), 32'd3);

    // sub with run pulsed in T2 (carrying an mv) is ignored
    step(1'b1, 16'h6C80, 1'b0);
    step(1'b1, 16'h0E80, 1'b0);
    check_eq("pulse_t2_alu", 32'(bus.addsub), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("pulse_no_extra", 32'(bus.busy), 32'd0);

    // jmp 0x1A5
    step(1'b1, 16'hC1A5, 1'b0);
    check_eq("jmp_in",   32'(bus.reg_enable_in), 32'h400);
    check_eq("jmp_addr", 32'(bus.addr), 32'h1A5);
    check_eq("jmp_done", 32'(bus.done), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("addr_hold", 32'(bus.addr), 32'h1A5);

    // opcode 111, rX=0, rY=1, with g_zero low then high
    step(1'b1, 16'hE080, 1'b0);
`ifdef MVNZ_EN
    check_eq("x111_gz0_out", 32'(bus.reg_enable_out), 32'h002);
    check_eq("x111_gz0_in",  32'(bus.reg_enable_in),  32'h001);
`else
    check_eq("x111_gz0_out", 32'(bus.reg_enable_out), 32'h000);
    check_eq("x111_gz0_in",  32'(bus.reg_enable_in),  32'h000);
`endif
    check_eq("x111_gz0_done", 32'(bus.done), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'hE080, 1'b1);
    check_eq("x111_gz1_in", 32'(bus.reg_enable_in), 32'h000);
    check_eq("x111_gz1_done", 32'(bus.done), 32'd1);
    step(1'b0, 16'h0000, 1'b0);

    // reset asserted mid-T2 of an add
    step(1'b1, 16'h4500, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    mid_cycle_reset();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    step(1'b0, 16'h0000, 1'b0);
    check_eq("post_rst_busy", 32'(bus.busy), 32'd0);

    // randomised traffic with occasional asynchronous resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) mid_cycle_reset();
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
